// File: rtl/mem_port_ctrl.sv
// Byte-serial load/store responder between the MEM stage and a byte-wide single-port RAM.
// Little-endian, one byte per cycle; load data is returned zero-extended with a done pulse.
module mem_port_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_TAIL, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        idx, idx_n;     // byte currently on ram_addr
  logic [1:0]        last, last_n;   // index of final byte (n-1)
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        dout_n;
  logic              wr_n, busy_n, done_n;
  logic [DATA_W-1:0] rdata_n;
  logic [1:0]        idx_inc, idx_dec, len_last;

  assign idx_inc  = idx + 2'd1;
  assign idx_dec  = idx - 2'd1;
  assign len_last = (mem_len == 2'b00) ? 2'd0 : (mem_len == 2'b01) ? 2'd1 : 2'd3;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    last_n  = last;
    wdata_n = wdata_q;
    addr_n  = ram_addr;
    dout_n  = 8'h00;
    wr_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    rdata_n = rdata;
    case (state)
      IDLE: begin
        addr_n = '0;
        if (mem_write) begin
          state_n = WRITE;
          idx_n   = 2'd0;
          last_n  = len_last;
          wdata_n = mem_wdata;
          addr_n  = mem_addr;
          wr_n    = 1'b1;
          dout_n  = mem_wdata[7:0];
          busy_n  = 1'b1;
        end else if (mem_read) begin
          state_n = READ;
          idx_n   = 2'd0;
          last_n  = len_last;
          addr_n  = mem_addr;
          busy_n  = 1'b1;
          rdata_n = '0;
        end
      end
      WRITE: begin
        busy_n = 1'b1;
        if (idx == last) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          idx_n  = idx_inc;
          addr_n = ram_addr + ADDR_W'(1);
          wr_n   = 1'b1;
          dout_n = wdata_q[{idx_inc, 3'b000} +: 8];
        end
      end
      READ: begin
        busy_n = 1'b1;
        // RAM returns a byte one cycle after its address, so capture trails by one
        if (idx != 2'd0)
          rdata_n[{idx_dec, 3'b000} +: 8] = ram_din;
        if (idx == last) begin
          state_n = READ_TAIL;
        end else begin
          idx_n  = idx_inc;
          addr_n = ram_addr + ADDR_W'(1);
        end
      end
      READ_TAIL: begin
        busy_n  = 1'b1;
        rdata_n[{idx, 3'b000} +: 8] = ram_din;
        state_n = DONE;
        done_n  = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
        addr_n  = '0;
      end
      default: begin
        state_n = IDLE;
        addr_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      last     <= 2'd0;
      wdata_q  <= '0;
      ram_addr <= '0;
      ram_dout <= 8'h00;
      ram_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      last     <= last_n;
      wdata_q  <= wdata_n;
      ram_addr <= addr_n;
      ram_dout <= dout_n;
      ram_wr   <= wr_n;
      busy     <= busy_n;
      done     <= done_n;
      rdata    <= rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural byte RAM (registered read port).
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        busy, done, ram_wr;
  logic [31:0] rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;

  logic [7:0] mem [logic [31:0]];

  mem_port_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
    .busy(busy), .done(done), .rdata(rdata),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr),
    .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    ram_din <= mem_rd(ram_addr);
    if (ram_wr) begin
      mem[ram_addr] = ram_dout;
      wr_count++;
    end
    if (done) done_count++;
  end

  // Counts cycles from request (driven at a negedge) until done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_len = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
    checks++; if (ram_wr !== 1'b0 || ram_dout !== 8'h00) begin
      errors++; $display("FAIL reset_ram_wr got %b/%h exp 0/00", ram_wr, ram_dout); end
    rst = 1'b0;
  endtask

  task automatic test_sw;
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    mem_write = 1'b1; mem_addr = 32'h100; mem_wdata = wd; mem_len = 2'b10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({ram_wr, ram_addr, ram_dout, busy, done} !== {1'b1, 32'h100 + k, wd[8*k +: 8], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL sw_byte%0d got wr=%b addr=%h dout=%h busy=%b done=%b exp wr=1 addr=%h dout=%h busy=1 done=0",
                 k, ram_wr, ram_addr, ram_dout, busy, done, 32'h100 + k, wd[8*k +: 8]);
      end
    end
    @(negedge clk);
    mem_write = 1'b0;
    checks++;
    if ({done, busy, ram_wr, ram_dout} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL sw_done got done=%b busy=%b wr=%b dout=%h exp 1 1 0 00", done, busy, ram_wr, ram_dout);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, ram_addr} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL sw_idle got done=%b busy=%b addr=%h exp 0 0 0", done, busy, ram_addr);
    end
    checks++;
    if ({mem_rd(32'h103), mem_rd(32'h102), mem_rd(32'h101), mem_rd(32'h100)} !== wd) begin
      errors++; $display("FAIL sw_ram got %h%h%h%h exp %h", mem_rd(32'h103), mem_rd(32'h102),
                         mem_rd(32'h101), mem_rd(32'h100), wd);
    end
  endtask

  task automatic test_lw;
    mem[32'h200] = 8'h11; mem[32'h201] = 8'h22; mem[32'h202] = 8'h33; mem[32'h203] = 8'h44;
    mem_read = 1'b1; mem_addr = 32'h200; mem_len = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({ram_addr, ram_wr, busy, done} !== {32'h200 + k - 1, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL lw_addr_T%0d got addr=%h wr=%b busy=%b done=%b exp addr=%h wr=0 busy=1 done=0",
                           k, ram_addr, ram_wr, busy, done, 32'h200 + k - 1);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL lw_T5 got busy=%b done=%b exp 1 0", busy, done); end
    @(negedge clk);
    mem_read = 1'b0;
    checks++;
    if ({done, rdata} !== {1'b1, 32'h44332211}) begin
      errors++; $display("FAIL lw_T6 got done=%b rdata=%h exp 1 44332211", done, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_lb_lh;
    int cyc;
    mem[32'h300] = 8'h80; mem[32'h301] = 8'hFF;
    mem_read = 1'b1; mem_addr = 32'h300; mem_len = 2'b00;
    @(negedge clk);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL lb_clear got %h exp 00000000", rdata); end
    wait_done(cyc);
    cyc = cyc + 1;
    checks++;
    if (cyc !== 3 || rdata !== 32'h00000080) begin
      errors++; $display("FAIL lb got cycles=%0d rdata=%h exp 3 00000080", cyc, rdata);
    end
    @(negedge clk);
    mem_read = 1'b1; mem_addr = 32'h300; mem_len = 2'b01;
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || rdata !== 32'h0000FF80) begin
      errors++; $display("FAIL lh got cycles=%0d rdata=%h exp 4 0000FF80", cyc, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int cyc;
    mem_write = 1'b1; mem_addr = 32'hFFFFFFFE; mem_wdata = 32'h01020304; mem_len = 2'b10;
    wait_done(cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL wrap_latency got %0d exp 5", cyc); end
    checks++;
    if ({mem_rd(32'hFFFFFFFE), mem_rd(32'hFFFFFFFF), mem_rd(32'h0), mem_rd(32'h1)} !== 32'h04030201) begin
      errors++; $display("FAIL wrap_ram got %h %h %h %h exp 04 03 02 01", mem_rd(32'hFFFFFFFE),
                         mem_rd(32'hFFFFFFFF), mem_rd(32'h0), mem_rd(32'h1));
    end
    @(negedge clk);
  endtask

  task automatic test_priority_hold;
    int cyc, w0;
    w0 = wr_count;
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h55; mem_len = 2'b00;
    wait_done(cyc);
    checks++;
    if (cyc !== 2 || wr_count - w0 !== 1 || mem_rd(32'h400) !== 8'h55 || rdata !== 32'h0000FF80) begin
      errors++; $display("FAIL priority got cycles=%0d writes=%0d ram=%h rdata=%h exp 2 1 55 0000FF80",
                         cyc, wr_count - w0, mem_rd(32'h400), rdata);
    end
    @(negedge clk);
    // change address and data while busy; latched values must be used
    mem_write = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h66; mem_len = 2'b00;
    @(negedge clk);
    mem_addr = 32'h600; mem_wdata = 32'h77;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL hold_done got %b exp 1", done); end
    // request stays asserted through the DONE cycle
    @(negedge clk);
    checks++;
    if ({busy, ram_wr} !== 2'b00) begin errors++; $display("FAIL hold_idle got busy=%b wr=%b exp 0 0", busy, ram_wr); end
    @(negedge clk);
    checks++;
    if ({busy, ram_wr, ram_addr} !== {1'b1, 1'b1, 32'h600}) begin
      errors++; $display("FAIL hold_reaccept got busy=%b wr=%b addr=%h exp 1 1 00000600", busy, ram_wr, ram_addr);
    end
    wait_done(cyc);
    checks++;
    if (mem_rd(32'h500) !== 8'h66 || mem_rd(32'h600) !== 8'h77) begin
      errors++; $display("FAIL hold_ram got %h %h exp 66 77", mem_rd(32'h500), mem_rd(32'h600));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, d0;
    d0 = done_count;
    mem_write = 1'b1; mem_addr = 32'h700; mem_wdata = 32'hCAFEBABE; mem_len = 2'b10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ram_wr, busy, done} !== 3'b000) begin
      errors++; $display("FAIL rst_mid got wr=%b busy=%b done=%b exp 0 0 0", ram_wr, busy, done);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_count !== d0 || mem_rd(32'h700) !== 8'hBE || mem_rd(32'h701) !== 8'hBA || mem.exists(32'h702)) begin
      errors++; $display("FAIL rst_mid_ram got dones=%0d ram=%h %h exists702=%0d exp 0 BE BA 0",
                         done_count - d0, mem_rd(32'h700), mem_rd(32'h701), mem.exists(32'h702));
    end
    mem_write = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hAA; mem_len = 2'b00;
    wait_done(cyc);
    checks++;
    if (cyc !== 2 || mem_rd(32'h10) !== 8'hAA) begin
      errors++; $display("FAIL rst_sb got cycles=%0d ram=%h exp 2 AA", cyc, mem_rd(32'h10));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_sw;
    test_lw;
    test_lb_lh;
    test_wrap;
    test_priority_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
